// File: rtl/nes_joy_pkg.sv
// Shared button-bit positions, Four Score signatures and the per-pad effective-button function
// used by the NES joypad serializer.
package nes_joy_pkg;

    localparam int BTN_A       = 0;
    localparam int BTN_B       = 1;
    localparam int BTN_SEL     = 2;
    localparam int BTN_START   = 3;
    localparam int BTN_UP      = 4;
    localparam int BTN_DN      = 5;
    localparam int BTN_LT      = 6;
    localparam int BTN_RT      = 7;
    localparam int BTN_TURBO_A = 8;
    localparam int BTN_TURBO_B = 9;

    localparam logic [7:0] FS_SIG_P1 = 8'h08;
    localparam logic [7:0] FS_SIG_P2 = 8'h04;

    // Four Score frame length: 8 bits per pad for two pads plus an 8-bit signature.
    localparam int SR_W = 24;

    typedef logic [11:0] snes_btn_t;
    typedef logic [7:0]  nes_btn_t;

    // Autofire OR-in first, then opposite-direction cancel on the result.
    function automatic nes_btn_t effective_buttons(snes_btn_t btn, logic af_phase, logic socd_mask);
        nes_btn_t eff;
        logic     unused_hi;
        unused_hi  = ^btn[11:10];
        eff        = btn[7:0];
        eff[BTN_A] = btn[BTN_A] | (btn[BTN_TURBO_A] & af_phase);
        eff[BTN_B] = btn[BTN_B] | (btn[BTN_TURBO_B] & af_phase);
        if (socd_mask && eff[BTN_UP] && eff[BTN_DN]) begin
            eff[BTN_UP] = 1'b0;
            eff[BTN_DN] = 1'b0;
        end
        if (socd_mask && eff[BTN_LT] && eff[BTN_RT]) begin
            eff[BTN_LT] = 1'b0;
            eff[BTN_RT] = 1'b0;
        end
        return eff;
    endfunction

endpackage

// File: rtl/nes_joypad_serializer_if.sv
// Controller-port bundle between the console side (master) and the joypad serializer (slave).
interface nes_joypad_serializer_if #(
    parameter int NUM_PADS = 2
);
    logic [NUM_PADS*12-1:0] pad_btns;
    logic                   strobe;
    logic [1:0]             joy_clk;
    logic                   four_score_en;
    logic                   socd_mask;
    logic [1:0]             joy_data;

    modport master (
        output pad_btns, strobe, joy_clk, four_score_en, socd_mask,
        input  joy_data
    );

    modport slave (
        input  pad_btns, strobe, joy_clk, four_score_en, socd_mask,
        output joy_data
    );
endinterface

// File: rtl/nes_joy_port.sv
// One NES controller port: 24-bit self-filling shift register with parallel load on strobe
// and shift on each falling edge of the port's read clock.
module nes_joy_port
    import nes_joy_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [SR_W-1:0] load_val,
    input  logic            strobe,
    input  logic            joy_clk,
    output logic            joy_data
);

    logic [SR_W-1:0] sr;
    logic            last_clk;

    // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr       <= '0;
            last_clk <= 1'b0;
        end else begin
            last_clk <= joy_clk;
            // Strobe has priority: a coincident falling edge is swallowed by the load.
            if (strobe) begin
                sr <= load_val;
            end else if (last_clk && !joy_clk) begin
                sr <= {1'b1, sr[SR_W-1:1]};
            end
        end
    end

    assign joy_data = sr[0];

endmodule

// File: rtl/nes_joypad_serializer.sv
// NES controller-port serializer: shared autofire, SOCD masking and standard / Four Score
// load-word selection feeding two independent port shift registers.
module nes_joypad_serializer
    import nes_joy_pkg::*;
#(
    parameter int NUM_PADS     = 2,
    parameter int AUTOFIRE_DIV = 715_909
) (
    input  logic                    clk,
    input  logic                    reset,
    nes_joypad_serializer_if.slave  bus
);

    generate
        if (!(NUM_PADS == 2 || NUM_PADS == 4)) begin : g_bad_num_pads
            $error("nes_joypad_serializer: NUM_PADS must be 2 or 4");
        end
        if (AUTOFIRE_DIV < 1) begin : g_bad_div
            $error("nes_joypad_serializer: AUTOFIRE_DIV must be at least 1");
        end
    endgenerate

    localparam int                CNT_W   = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(AUTOFIRE_DIV - 1);

    logic [CNT_W-1:0] af_cnt;
    logic             af_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            af_cnt   <= '0;
            af_phase <= 1'b0;
        end else if (af_cnt == CNT_MAX) begin
            af_cnt   <= '0;
            af_phase <= ~af_phase;
        end else begin
            af_cnt   <= af_cnt + CNT_W'(1);
        end
    end

    nes_btn_t eff [NUM_PADS];

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        assign eff[p] = effective_buttons(snes_btn_t'(bus.pad_btns[12*p +: 12]), af_phase, bus.socd_mask);
    end

    logic [SR_W-1:0] load_val [2];

    if (NUM_PADS == 4) begin : g_four_score
        // NOTE: defaults are assigned first so no path leaves load_val unassigned (no latch).
        always_comb begin
            load_val[0] = {16'hFFFF, eff[0]};
            load_val[1] = {16'hFFFF, eff[1]};
            if (bus.four_score_en) begin
                load_val[0] = {FS_SIG_P1, eff[2], eff[0]};
                load_val[1] = {FS_SIG_P2, eff[3], eff[1]};
            end
        end
    end else begin : g_two_pad
        logic unused_four_score;
        assign unused_four_score = bus.four_score_en;

        always_comb begin
            load_val[0] = {16'hFFFF, eff[0]};
            load_val[1] = {16'hFFFF, eff[1]};
        end
    end

    logic [1:0] joy_data;

    for (genvar q = 0; q < 2; q++) begin : g_port
        nes_joy_port u_port (
            .clk      (clk),
            .reset    (reset),
            .load_val (load_val[q]),
            .strobe   (bus.strobe),
            .joy_clk  (bus.joy_clk[q]),
            .joy_data (joy_data[q])
        );
    end

    assign bus.joy_data = joy_data;

endmodule

// File: tb/tb_nes_joypad_serializer.sv
// Bench for nes_joypad_serializer: a 4-pad and a 2-pad instance share stimulus; a read-index
// model checks both every cycle, and directed reads pin the model with literal streams.
module tb_nes_joypad_serializer;
    import nes_joy_pkg::*;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nes_joypad_serializer_if #(.NUM_PADS(4)) bus4 ();
    nes_joypad_serializer_if #(.NUM_PADS(2)) bus2 ();

    assign bus2.pad_btns      = bus4.pad_btns[23:0];
    assign bus2.strobe        = bus4.strobe;
    assign bus2.joy_clk       = bus4.joy_clk;
    assign bus2.four_score_en = bus4.four_score_en;
    assign bus2.socd_mask     = bus4.socd_mask;

    nes_joypad_serializer #(.NUM_PADS(4), .AUTOFIRE_DIV(DIV)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    nes_joypad_serializer #(.NUM_PADS(2), .AUTOFIRE_DIV(DIV)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model: each port holds the last loaded frame and how many bits have been read since.
    logic [23:0] m_word  [2][2];
    int          m_reads [2][2];
    logic [1:0]  m_prev;
    int          m_edges;
    bit          m_valid = 1'b0;

    function automatic logic [7:0] model_eff(logic [11:0] b, bit af, bit socd);
        bit a, bb, sel, start, up, dn, lt, rt;
        a  = b[0] | (b[8] & af);
        bb = b[1] | (b[9] & af);
        sel = b[2]; start = b[3]; up = b[4]; dn = b[5]; lt = b[6]; rt = b[7];
        if (socd && up && dn) begin up = 0; dn = 0; end
        if (socd && lt && rt) begin lt = 0; rt = 0; end
        return {rt, lt, dn, up, start, sel, bb, a};
    endfunction

    function automatic logic model_bit(int d, int q);
        if (m_reads[d][q] < 24) return m_word[d][q][m_reads[d][q]];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        logic [7:0] e [4];
        bit af;
        if (reset) begin
            for (int d = 0; d < 2; d++)
                for (int q = 0; q < 2; q++) begin
                    m_word[d][q]  = '0;
                    m_reads[d][q] = 0;
                end
            m_prev  = 2'b00;
            m_edges = 0;
            m_valid = 1'b1;
        end else begin
            af = ((m_edges / DIV) % 2) == 1;
            for (int p = 0; p < 4; p++)
                e[p] = model_eff(bus4.pad_btns[12*p +: 12], af, bus4.socd_mask);
            for (int d = 0; d < 2; d++)
                for (int q = 0; q < 2; q++) begin
                    if (bus4.strobe) begin
                        if (d == 0 && bus4.four_score_en)
                            m_word[d][q] = (q == 0) ? {8'h08, e[2], e[0]} : {8'h04, e[3], e[1]};
                        else
                            m_word[d][q] = {16'hFFFF, e[q]};
                        m_reads[d][q] = 0;
                    end else if (m_prev[q] && !bus4.joy_clk[q]) begin
                        m_reads[d][q]++;
                    end
                end
            m_prev = bus4.joy_clk;
            m_edges++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int q = 0; q < 2; q++) begin
                check($sformatf("model 4pad port%0d", q), 32'(bus4.joy_data[q]), 32'(model_bit(0, q)));
                check($sformatf("model 2pad port%0d", q), 32'(bus2.joy_data[q]), 32'(model_bit(1, q)));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_strobe();
        bus4.strobe = 1'b1;
        tick();
        bus4.strobe = 1'b0;
        tick();
    endtask

    task automatic edge_port(input int q);
        bus4.joy_clk[q] = 1'b1;
        tick();
        bus4.joy_clk[q] = 1'b0;
        tick();
    endtask

    task automatic read_port(input int q, output logic b4, output logic b2);
        b4 = bus4.joy_data[q];
        b2 = bus2.joy_data[q];
        edge_port(q);
    endtask

    task automatic run_standard_read(input string tag);
        logic [9:0] exp_p0;
        logic [9:0] exp_p1;
        logic b4, b2, other;
        exp_p0 = 10'b11_0000_0001;
        exp_p1 = 10'b11_0000_0000;
        bus4.four_score_en = 1'b0;
        bus4.socd_mask     = 1'b0;
        bus4.pad_btns      = {12'h000, 12'h000, 12'h000, 12'h001};
        do_strobe();
        for (int i = 0; i < 10; i++) begin
            other = bus4.joy_data[1];
            read_port(0, b4, b2);
            check($sformatf("%s p0 read%0d", tag, i + 1), 32'(b4), 32'(exp_p0[i]));
            check($sformatf("%s p0 read%0d 2pad", tag, i + 1), 32'(b2), 32'(exp_p0[i]));
            check($sformatf("%s p1 idle%0d", tag, i + 1), 32'(other), 32'd0);
        end
        for (int i = 0; i < 10; i++) begin
            read_port(1, b4, b2);
            check($sformatf("%s p1 read%0d", tag, i + 1), 32'(b4), 32'(exp_p1[i]));
        end
    endtask

    initial begin
        logic b4, b2;
        logic [24:0] exp_fs0;
        logic [24:0] exp_fs1;
        logic        samp [16];
        logic        r [8];

        reset              = 1'b1;
        bus4.pad_btns      = '0;
        bus4.strobe        = 1'b0;
        bus4.joy_clk       = 2'b00;
        bus4.four_score_en = 1'b0;
        bus4.socd_mask     = 1'b0;
        tick(2);
        check("reset joy_data 4pad", 32'(bus4.joy_data), 32'd0);
        check("reset joy_data 2pad", 32'(bus2.joy_data), 32'd0);
        reset = 1'b0;
        tick();

        // Standard two-pad read
        run_standard_read("s1");

        // Four Score frame
        exp_fs0 = {1'b1, 8'h08, 8'h80, 8'h01};
        exp_fs1 = {1'b1, 8'h04, 8'h40, 8'h02};
        bus4.four_score_en = 1'b1;
        bus4.pad_btns      = {12'h040, 12'h080, 12'h002, 12'h001};
        do_strobe();
        for (int i = 0; i < 25; i++) begin
            read_port(0, b4, b2);
            check($sformatf("s2 fs p0 read%0d", i + 1), 32'(b4), 32'(exp_fs0[i]));
        end
        for (int i = 0; i < 25; i++) begin
            read_port(1, b4, b2);
            check($sformatf("s2 fs p1 read%0d", i + 1), 32'(b4), 32'(exp_fs1[i]));
        end
        bus4.four_score_en = 1'b0;

        // Autofire with strobe held high
        bus4.pad_btns = {36'h0, 12'h100};
        bus4.strobe   = 1'b1;
        tick(2);
        for (int i = 0; i < 16; i++) begin
            samp[i] = bus4.joy_data[0];
            tick();
        end
        for (int i = 0; i < 12; i++)
            check($sformatf("s3 turbo toggles %0d", i), 32'(samp[i] ^ samp[i + 4]), 32'd1);
        bus4.pad_btns = {36'h0, 12'h101};
        tick();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("s3 held A %0d", i), 32'(bus4.joy_data[0]), 32'd1);
            tick();
        end
        bus4.strobe = 1'b0;
        tick();

        // SOCD: Up+Down+Left
        bus4.pad_btns  = {36'h0, 12'h070};
        bus4.socd_mask = 1'b1;
        do_strobe();
        for (int i = 0; i < 8; i++) read_port(0, r[i], b2);
        check("s4 socd on up",   32'(r[4]), 32'd0);
        check("s4 socd on dn",   32'(r[5]), 32'd0);
        check("s4 socd on lt",   32'(r[6]), 32'd1);
        bus4.socd_mask = 1'b0;
        do_strobe();
        for (int i = 0; i < 8; i++) read_port(0, r[i], b2);
        check("s4 socd off up",  32'(r[4]), 32'd1);
        check("s4 socd off dn",  32'(r[5]), 32'd1);
        check("s4 socd off lt",  32'(r[6]), 32'd1);

        // Strobe coincident with a falling edge
        bus4.pad_btns   = {36'h0, 12'h001};
        bus4.joy_clk[0] = 1'b1;
        tick();
        bus4.strobe     = 1'b1;
        bus4.joy_clk[0] = 1'b0;
        tick();
        check("s5 collision load", 32'(bus4.joy_data[0]), 32'd1);
        bus4.strobe = 1'b0;
        tick();
        check("s5 collision no shift", 32'(bus4.joy_data[0]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            edge_port(0);
            check($sformatf("s5 after edge%0d", i + 1), 32'(bus4.joy_data[0]), 32'd0);
        end

        // Reset mid-read, then a fresh read
        do_strobe();
        for (int i = 0; i < 3; i++) edge_port(0);
        reset = 1'b1;
        tick();
        check("s6 reset 4pad", 32'(bus4.joy_data), 32'd0);
        check("s6 reset 2pad", 32'(bus2.joy_data), 32'd0);
        reset = 1'b0;
        tick();
        run_standard_read("s6");

        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
